// File: rtl/mult_div.sv
// Iterative 32x32 signed multiply / divide unit. Operates on operand magnitudes
// for 32 cycles and applies the result signs on the completing edge.
module mult_div (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        MultStart,
  input  logic        DivStart,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        Busy,
  output logic        Done,
  output logic        DivZero,
  output logic [1:0]  fsm_state
);

  // Handshake: a start is taken only while Busy=0 (IDLE); Done pulses for one
  // cycle with Hi/Lo already valid, and DivZero is meaningful only alongside it.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MULT = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state;
  logic [5:0]  count;
  logic [63:0] work;
  logic [63:0] work_next;
  logic [63:0] result;
  logic [63:0] shifted;
  logic [32:0] sum;
  logic [32:0] diff;
  logic [31:0] opr;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        neg_q;
  logic        neg_r;
  logic        dz;

  assign a_mag = A[31] ? -A : A;
  assign b_mag = B[31] ? -B : B;

  // Multiply: shift-add with carry into the upper word. Divide: restoring
  // division, remainder in the upper word and quotient bits shifted into the lower.
  always_comb begin
    sum       = {1'b0, work[63:32]} + (work[0] ? {1'b0, opr} : 33'd0);
    shifted   = {work[62:0], 1'b0};
    diff      = {1'b0, shifted[63:32]} - {1'b0, opr};
    work_next = work;
    if (state == MULT) begin
      work_next = {sum, work[31:1]};
    end else if (state == DIV) begin
      work_next = diff[32] ? shifted : {diff[31:0], shifted[31:1], 1'b1};
    end
    result = work_next;
    if (state == MULT) begin
      if (neg_q) result = -work_next;
    end else begin
      if (neg_q) result[31:0]  = -work_next[31:0];
      if (neg_r) result[63:32] = -work_next[63:32];
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      count <= 6'd0;
      work  <= 64'd0;
      opr   <= 32'd0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz    <= 1'b0;
      Hi    <= 32'd0;
      Lo    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          dz <= 1'b0;
          if (MultStart) begin
            work  <= {32'd0, b_mag};
            opr   <= a_mag;
            neg_q <= A[31] ^ B[31];
            neg_r <= A[31];
            count <= 6'd0;
            state <= MULT;
          end else if (DivStart) begin
            if (B == 32'd0) begin
              dz    <= 1'b1;
              state <= DONE;
            end else begin
              work  <= {32'd0, a_mag};
              opr   <= b_mag;
              neg_q <= A[31] ^ B[31];
              neg_r <= A[31];
              count <= 6'd0;
              state <= DIV;
            end
          end
        end
        MULT, DIV: begin
          work  <= work_next;
          count <= count + 6'd1;
          if (count == 6'd31) begin
            Hi    <= result[63:32];
            Lo    <= result[31:0];
            state <= DONE;
          end
        end
        DONE: begin
          dz    <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Busy      = (state != IDLE);
  assign Done      = (state == DONE);
  assign DivZero   = (state == DONE) && dz;
  assign fsm_state = state;

endmodule

// File: tb/tb_mult_div.sv
// Directed bench for mult_div: cycle-level arithmetic model checked every cycle,
// plus literal expected results queued per operation.
module tb_mult_div;

  logic        Clock;
  logic        Reset;
  logic        MultStart;
  logic        DivStart;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        Busy;
  logic        Done;
  logic        DivZero;
  logic [1:0]  fsm_state;

  mult_div dut (
    .Clock(Clock), .Reset(Reset), .MultStart(MultStart), .DivStart(DivStart),
    .A(A), .B(B), .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done),
    .DivZero(DivZero), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;
  logic [64:0] exp_q[$];

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int          m_left = 0;
  bit          m_dz = 1'b0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [63:0] m_pend = '0;
  longint      sa, sb, mp, mq, mr;

  always @(posedge Clock) begin
    if (Reset) begin
      m_left = 0; m_dz = 1'b0; m_hi = '0; m_lo = '0;
    end else if (m_left == 0) begin
      m_dz = 1'b0;
      sa = longint'($signed(A));
      sb = longint'($signed(B));
      if (MultStart) begin
        mp = sa * sb;
        m_pend = mp;
        m_left = 33;
      end else if (DivStart) begin
        if (B == 32'd0) begin
          m_dz = 1'b1;
          m_left = 1;
        end else begin
          mq = sa / sb;
          mr = sa % sb;
          m_pend = {mr[31:0], mq[31:0]};
          m_left = 33;
        end
      end
    end else begin
      m_left--;
      if (m_left == 1 && !m_dz) {m_hi, m_lo} = m_pend;
    end
  end

  // ---------------- compare / scoreboard ----------------
  logic [64:0] e;
  always @(negedge Clock) begin
    if (chk_en) begin
      check("busy",    Busy,    m_left != 0);
      check("done",    Done,    m_left == 1);
      check("divzero", DivZero, (m_left == 1) && m_dz);
      check("hi_lo",   {Hi, Lo}, {m_hi, m_lo});
      if (Done) begin
        check("done_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("result",    {DivZero, Hi, Lo}, e);
          check("model_pin", {m_dz, m_hi, m_lo}, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_op(input logic mul, input logic div, input logic [31:0] a,
                        input logic [31:0] b, input logic [64:0] exp, input int pulse_at);
    bit got = 1'b0;
    exp_q.push_back(exp);
    @(negedge Clock);
    MultStart = mul; DivStart = div; A = a; B = b;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge Clock);
      MultStart = (i == pulse_at);
      DivStart  = (i == pulse_at);
      A = $urandom; B = $urandom;
      if (Done) got = 1'b1;
    end
    MultStart = 1'b0; DivStart = 1'b0;
    check("op_completes", got, 1);
    if (!got) exp_q.delete();
    @(negedge Clock);
  endtask

  task automatic run_held_mult();
    int dones = 0;
    exp_q.push_back({1'b0, 32'h0, 32'hF});
    exp_q.push_back({1'b0, 32'h0, 32'hF});
    @(negedge Clock);
    MultStart = 1'b1; A = 32'd3; B = 32'd5;
    for (int i = 0; i < 100 && dones < 2; i++) begin
      @(negedge Clock);
      if (Done) dones++;
    end
    MultStart = 1'b0;
    check("held_two_ops", dones, 2);
    if (dones != 2) exp_q.delete();
    repeat (2) @(negedge Clock);
  endtask

  task automatic run_reset_abort();
    @(negedge Clock);
    MultStart = 1'b1; A = 32'h12345678; B = 32'h10;
    repeat (16) begin
      @(negedge Clock);
      MultStart = 1'b0;
    end
    Reset = 1'b1; MultStart = 1'b1; DivStart = 1'b1;
    @(negedge Clock);
    Reset = 1'b0; MultStart = 1'b0; DivStart = 1'b0;
    check("abort_hi_lo", {Hi, Lo}, 64'd0);
    check("abort_flags", {Busy, Done, DivZero}, 3'b000);
    repeat (3) @(negedge Clock);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    Reset = 1'b1; MultStart = 1'b0; DivStart = 1'b0; A = '0; B = '0;
    @(negedge Clock);
    chk_en = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    check("reset_hi_lo", {Hi, Lo}, 64'd0);
    check("reset_flags", {Busy, Done, DivZero}, 3'b000);

    run_op(1, 0, 32'd7,        32'hFFFFFFFD, {1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB}, -1);
    run_op(0, 1, 32'hFFFFFFF9, 32'd2,        {1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD}, -1);
    run_op(1, 0, 32'h55555556, 32'h33333333, {1'b0, 32'h11111111, 32'h22222222}, -1);
    run_op(0, 1, 32'd5,        32'd0,        {1'b1, 32'h11111111, 32'h22222222}, -1);
    run_op(0, 1, 32'h80000000, 32'hFFFFFFFF, {1'b0, 32'h00000000, 32'h80000000}, -1);
    run_op(1, 0, 32'h80000000, 32'hFFFFFFFF, {1'b0, 32'h00000000, 32'h80000000}, -1);
    run_op(1, 1, 32'd3,        32'd4,        {1'b0, 32'h00000000, 32'h0000000C}, -1);
    run_op(1, 0, 32'hFFFFFF9C, 32'd12345,    {1'b0, 32'hFFFFFFFF, 32'hFFED29BC},  9);
    run_op(0, 1, 32'd100,      32'hFFFFFFF9, {1'b0, 32'h00000002, 32'hFFFFFFF2}, -1);
    run_op(0, 1, 32'hFFFFFF9C, 32'hFFFFFFF9, {1'b0, 32'hFFFFFFFE, 32'h0000000E}, -1);
    run_op(0, 1, 32'h7FFFFFFF, 32'h80000000, {1'b0, 32'h7FFFFFFF, 32'h00000000}, -1);
    run_op(1, 0, 32'h80000000, 32'h80000000, {1'b0, 32'h40000000, 32'h00000000}, -1);
    run_held_mult();
    run_reset_abort();
    run_op(0, 1, 32'd1000,     32'd7,        {1'b0, 32'h00000006, 32'h0000008E}, -1);

    repeat (3) @(negedge Clock);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
